// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction-fetch unit: data width, reset/bubble
// encodings and the fetch sequencer state type.
package ifu_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INST_DEF = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } fetch_state_e;

    // Fetch addresses are word aligned; the low two bits of a target are ignored.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifu_skid_buf.sv
// One-entry {pc,inst} holding register, used to park a fetched instruction while
// the DE stage is stalled.
module ifu_skid_buf
    import ifu_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_INST = NOP_INST_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_i,
    input  logic            clear_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] inst_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] inst_o
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] inst_q;

    // Entry register: load wins over clear; a cleared entry reads back as a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q   <= {XLEN{1'b0}};
            inst_q <= NOP_INST;
        end else if (load_i) begin
            pc_q   <= pc_i;
            inst_q <= inst_i;
        end else if (clear_i) begin
            pc_q   <= {XLEN{1'b0}};
            inst_q <= NOP_INST;
        end
    end

    assign pc_o   = pc_q;
    assign inst_o = inst_q;

endmodule

// File: rtl/ifu_fetch_ctrl.sv
// IF-stage fetch sequencer: single-outstanding instruction memory requests,
// PC generation, redirect/kill handling and the IF/DE pipeline register.
module ifu_fetch_ctrl
    import ifu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
    parameter logic [XLEN-1:0] NOP_INST = NOP_INST_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            de_valid_o,
    output logic [XLEN-1:0] de_pc_o,
    output logic [XLEN-1:0] de_inst_o
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] fpc_q, fpc_d;
    logic            kill_q, kill_d;
    logic            de_valid_q, de_valid_d;
    logic [XLEN-1:0] de_pc_q, de_pc_d;
    logic [XLEN-1:0] de_inst_q, de_inst_d;

    logic            load_s;
    logic [XLEN-1:0] load_pc_s;
    logic [XLEN-1:0] load_inst_s;
    logic            skid_load_s;
    logic            skid_clear_s;
    logic [XLEN-1:0] skid_pc_s;
    logic [XLEN-1:0] skid_inst_s;
    logic [XLEN-1:0] redir_pc_s;

    assign redir_pc_s = align_pc(redirect_pc_i);

    ifu_skid_buf #(
        .NOP_INST (NOP_INST)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (skid_load_s),
        .clear_i (skid_clear_s),
        .pc_i    (fpc_q),
        .inst_i  (imem_rdata),
        .pc_o    (skid_pc_s),
        .inst_o  (skid_inst_s)
    );

    // Sequencer next state, PC/kill updates and DE load-event selection.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        fpc_d        = fpc_q;
        kill_d       = kill_q;
        load_s       = 1'b0;
        load_pc_s    = fpc_q;
        load_inst_s  = imem_rdata;
        skid_load_s  = 1'b0;
        skid_clear_s = 1'b0;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_REQ;
            end
            ST_REQ: begin
                if (imem_gnt) begin
                    state_d = ST_WAIT;
                    fpc_d   = pc_q;
                    if (redirect_i) begin
                        // The granted fetch is already stale; its response must be dropped.
                        kill_d = 1'b1;
                        pc_d   = redir_pc_s;
                    end else begin
                        pc_d = pc_q + 32'd4;
                    end
                end else if (redirect_i) begin
                    pc_d = redir_pc_s;
                end else begin
                    pc_d = pc_q;
                end
            end
            ST_WAIT: begin
                if (redirect_i) begin
                    pc_d = redir_pc_s;
                    if (imem_rvalid) begin
                        kill_d  = 1'b0;
                        state_d = ST_REQ;
                    end else begin
                        kill_d = 1'b1;
                    end
                end else if (imem_rvalid) begin
                    state_d = ST_REQ;
                    if (kill_q) begin
                        kill_d = 1'b0;
                    end else if (!stall_i || !de_valid_q) begin
                        load_s = 1'b1;
                    end else begin
                        skid_load_s = 1'b1;
                        state_d     = ST_HOLD;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_HOLD: begin
                if (redirect_i) begin
                    skid_clear_s = 1'b1;
                    pc_d         = redir_pc_s;
                    state_d      = ST_REQ;
                end else if (!stall_i) begin
                    load_s      = 1'b1;
                    load_pc_s   = skid_pc_s;
                    load_inst_s = skid_inst_s;
                    state_d     = ST_REQ;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // DE register next value: redirect flush, then stall hold, then load, else bubble.
    always_comb begin
        de_valid_d = 1'b0;
        de_pc_d    = {XLEN{1'b0}};
        de_inst_d  = NOP_INST;
        if (redirect_i) begin
            de_valid_d = 1'b0;
        end else if (stall_i && de_valid_q) begin
            de_valid_d = de_valid_q;
            de_pc_d    = de_pc_q;
            de_inst_d  = de_inst_q;
        end else if (load_s) begin
            de_valid_d = 1'b1;
            de_pc_d    = load_pc_s;
            de_inst_d  = load_inst_s;
        end else begin
            de_valid_d = 1'b0;
        end
    end

    // State, PC, kill and DE pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_PC;
            fpc_q      <= {XLEN{1'b0}};
            kill_q     <= 1'b0;
            de_valid_q <= 1'b0;
            de_pc_q    <= {XLEN{1'b0}};
            de_inst_q  <= NOP_INST;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fpc_q      <= fpc_d;
            kill_q     <= kill_d;
            de_valid_q <= de_valid_d;
            de_pc_q    <= de_pc_d;
            de_inst_q  <= de_inst_d;
        end
    end

    assign imem_req   = (state_q == ST_REQ);
    assign imem_addr  = pc_q;
    assign de_valid_o = de_valid_q;
    assign de_pc_o    = de_pc_q;
    assign de_inst_o  = de_inst_q;

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Randomized bench for ifu_fetch_ctrl: a memory model with variable grant and
// response latency, plus a program-order scoreboard for the DE stream.
module tb_ifu_fetch_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'h0;
    logic        de_valid_o;
    logic [31:0] de_pc_o;
    logic [31:0] de_inst_o;

    int n_checks = 0;
    int n_fail   = 0;
    int n_loads  = 0;

    // Expected program-order PCs of the next instructions to reach DE.
    logic [31:0] exp_q[$];

    int          gnt_pct    = 100;
    int          stall_pct  = 0;
    int          redir_pct  = 0;
    int          max_dly    = 0;
    int          redir_mode = 0;
    logic [31:0] redir_tgt  = 32'h0;

    bit          outstanding = 1'b0;
    int          dly = 0;
    logic [31:0] o_addr = 32'h0;

    ifu_fetch_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .de_valid_o    (de_valid_o),
        .de_pc_o       (de_pc_o),
        .de_inst_o     (de_inst_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus: memory responses, stall and redirect.
    task automatic cycle();
        logic        req, g, rv, rd;
        logic [31:0] a, t;
        @(negedge clk);
        req = imem_req;
        a   = imem_addr;
        chk("one_outstanding", {31'b0, req && outstanding}, 32'd0);
        rv = outstanding && (dly == 0);
        imem_rvalid = rv;
        imem_rdata  = rv ? mem_word(o_addr) : $urandom;
        g = req && !outstanding && ($urandom_range(0, 99) < gnt_pct);
        imem_gnt = g;
        stall_i  = ($urandom_range(0, 99) < stall_pct);
        rd = 1'b0;
        t  = redir_tgt;
        case (redir_mode)
            1: rd = outstanding && !rv;
            2: rd = g;
            3: rd = 1'b1;
            default: begin
                if ($urandom_range(0, 99) < redir_pct) begin
                    rd = 1'b1;
                    case ($urandom_range(0, 3))
                        0: t = 32'h0000_0100;
                        1: t = 32'h0000_0203;
                        2: t = 32'hFFFF_FFF8;
                        default: t = $urandom;
                    endcase
                end
            end
        endcase
        if (rd) begin
            redir_mode = 0;
            exp_q.delete();
            exp_q.push_back(t & 32'hFFFF_FFFC);
        end
        redirect_i    = rd;
        redirect_pc_i = t;
        @(posedge clk);
        if (rv) outstanding = 1'b0;
        else if (outstanding) dly--;
        if (g) begin
            outstanding = 1'b1;
            o_addr      = a;
            dly         = $urandom_range(0, max_dly);
        end
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    // Monitor: fetch-address model and DE scoreboard, sampled just after each edge.
    initial begin
        logic        pv, s_stall, s_redir, s_req, s_gnt;
        logic [31:0] ppc, pinst, s_tgt, s_addr, fetch_exp, e;
        pv = 1'b0; ppc = 32'h0; pinst = NOP; fetch_exp = RPC;
        forever begin
            @(posedge clk);
            s_stall = stall_i;
            s_redir = redirect_i;
            s_tgt   = redirect_pc_i & 32'hFFFF_FFFC;
            s_req   = imem_req;
            s_addr  = imem_addr;
            s_gnt   = imem_gnt;
            #1;
            if (!rst_n) begin
                chk("rst_de_valid", {31'b0, de_valid_o}, 32'd0);
                chk("rst_de_pc", de_pc_o, 32'h0);
                chk("rst_de_inst", de_inst_o, NOP);
                chk("rst_imem_req", {31'b0, imem_req}, 32'd0);
                exp_q.delete();
                exp_q.push_back(RPC);
                fetch_exp = RPC;
                pv = 1'b0; ppc = 32'h0; pinst = NOP;
            end else begin
                if (s_req) begin
                    chk("imem_addr", s_addr, fetch_exp);
                    if (s_gnt) fetch_exp = fetch_exp + 32'd4;
                end
                if (s_redir) fetch_exp = s_tgt;
                if (s_redir) begin
                    chk("redir_de_valid", {31'b0, de_valid_o}, 32'd0);
                    chk("redir_de_pc", de_pc_o, 32'h0);
                    chk("redir_de_inst", de_inst_o, NOP);
                end else if (s_stall && pv) begin
                    chk("hold_de_valid", {31'b0, de_valid_o}, 32'd1);
                    chk("hold_de_pc", de_pc_o, ppc);
                    chk("hold_de_inst", de_inst_o, pinst);
                end else if (de_valid_o) begin
                    n_loads++;
                    if (exp_q.size() == 0) begin
                        chk("scoreboard_empty", de_pc_o, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("de_pc", de_pc_o, e);
                        chk("de_inst", de_inst_o, mem_word(e));
                        if (exp_q.size() == 0) exp_q.push_back(e + 32'd4);
                    end
                end else begin
                    chk("bubble_de_pc", de_pc_o, 32'h0);
                    chk("bubble_de_inst", de_inst_o, NOP);
                end
                pv = de_valid_o; ppc = de_pc_o; pinst = de_inst_o;
            end
        end
    end

    initial begin
        int l0, k;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back fetch, 1-cycle memory: one instruction every two cycles.
        l0 = n_loads;
        run(20);
        chk("throughput", {31'b0, (n_loads - l0) >= 9}, 32'd1);

        // Long stall while a response arrives.
        stall_pct = 100;
        run(6);
        stall_pct = 0;
        run(8);

        // Redirect while waiting on memory: late data dropped.
        max_dly = 3; redir_tgt = 32'h0000_0100; redir_mode = 1;
        run(14);
        chk("redir_wait_issued", redir_mode, 0);

        // Redirect in the same cycle as the grant.
        max_dly = 0; redir_tgt = 32'h0000_0240; redir_mode = 2;
        run(12);
        chk("redir_gnt_issued", redir_mode, 0);

        // Unaligned target and PC wrap-around.
        redir_tgt = 32'h0000_0203; redir_mode = 3;
        run(10);
        redir_tgt = 32'hFFFF_FFFC; redir_mode = 3;
        run(12);

        // Reset while a fetch is outstanding; a stale response follows.
        max_dly = 3;
        k = 0;
        while (!(outstanding && dly >= 1) && k < 40) begin
            cycle();
            k++;
        end
        chk("reach_wait", {31'b0, outstanding && dly >= 1}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0; imem_gnt = 1'b0; redirect_i = 1'b0; imem_rvalid = 1'b0; stall_i = 1'b0;
        #1;
        chk("async_rst_de_valid", {31'b0, de_valid_o}, 32'd0);
        chk("async_rst_imem_req", {31'b0, imem_req}, 32'd0);
        outstanding = 1'b0;
        @(negedge clk);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        rst_n = 1'b1;
        max_dly = 0;
        l0 = n_loads;
        run(20);
        chk("post_reset_progress", {31'b0, (n_loads - l0) >= 5}, 32'd1);

        // Random traffic.
        gnt_pct = 70; stall_pct = 30; redir_pct = 4; max_dly = 3;
        l0 = n_loads;
        run(2000);
        chk("random_progress", {31'b0, (n_loads - l0) >= 150}, 32'd1);

        stall_i = 1'b0; redirect_i = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
